// File: rtl/systolic_result_drain_if.sv
// Output stream bundle of the systolic result drain: one word per valid/ready handshake,
// tagged with its snapshot index and a last marker.
interface systolic_result_drain_if #(
  parameter int BIT_WIDTH   = 32,
  parameter int INDEX_WIDTH = 2
) ();
  logic                   out_valid;
  logic                   out_ready;
  logic [BIT_WIDTH-1:0]   out_data;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures a parallel snapshot of NUM_WORDS accumulator words on load and streams them out
// one per handshake, so the array can start its next computation while results drain.
module systolic_result_drain #(
  parameter int BIT_WIDTH   = 32,
  parameter int NUM_WORDS   = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [NUM_WORDS*BIT_WIDTH-1:0] data_in,
  output logic                           load_ready,
  output logic                           busy,
  output logic                           done,
  systolic_result_drain_if.master        out_bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_WORDS - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = INDEX_WIDTH'(0);

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   load_accept_s;
  logic                   handshake_s;
  logic                   final_s;
  logic [INDEX_WIDTH-1:0] idx_r;
  logic [INDEX_WIDTH-1:0] idx_next_s;
  logic [BIT_WIDTH-1:0]   next_word_s;
  logic [BIT_WIDTH-1:0]   snap_r [NUM_WORDS];

  logic                   out_valid_r;
  logic [BIT_WIDTH-1:0]   out_data_r;
  logic                   out_last_r;
  logic                   busy_r;
  logic                   load_ready_r;
  logic                   done_r;

  // Next-state decode: load accepted only in IDLE, drain ends on the last word's handshake
  always_comb begin
    next_state_s  = state_r;
    load_accept_s = 1'b0;
    handshake_s   = 1'b0;
    final_s       = 1'b0;
    idx_next_s    = idx_r + IDX_ONE;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          load_accept_s = 1'b1;
          next_state_s  = ST_DRAIN;
        end else begin
          next_state_s  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_valid_r && out_bus.out_ready) begin
          handshake_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            final_s      = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Word that follows the current one in the snapshot
  always_comb begin
    next_word_s = {BIT_WIDTH{1'b0}};
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx_next_s == INDEX_WIDTH'(k)) begin
        next_word_s = snap_r[k];
      end else begin
        next_word_s = next_word_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Snapshot, index and registered stream outputs; outputs are loaded one cycle ahead so
  // the next word appears right after a handshake with no bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r       <= '{default: {BIT_WIDTH{1'b0}}};
      idx_r        <= IDX_ZERO;
      out_valid_r  <= 1'b0;
      out_data_r   <= {BIT_WIDTH{1'b0}};
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      load_ready_r <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      out_valid_r  <= (next_state_s == ST_DRAIN);
      busy_r       <= (next_state_s == ST_DRAIN);
      load_ready_r <= (next_state_s == ST_IDLE);
      done_r       <= final_s;
      if (load_accept_s) begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          snap_r[k] <= data_in[k*BIT_WIDTH +: BIT_WIDTH];
        end
        idx_r      <= IDX_ZERO;
        out_data_r <= data_in[BIT_WIDTH-1:0];
        out_last_r <= (LAST_IDX == IDX_ZERO);
      end else if (final_s) begin
        idx_r      <= IDX_ZERO;
        out_data_r <= {BIT_WIDTH{1'b0}};
        out_last_r <= 1'b0;
      end else if (handshake_s) begin
        idx_r      <= idx_next_s;
        out_data_r <= next_word_s;
        out_last_r <= (idx_next_s == LAST_IDX);
      end else begin
        idx_r      <= idx_r;
        out_data_r <= out_data_r;
        out_last_r <= out_last_r;
      end
    end
  end

  assign out_bus.out_valid = out_valid_r;
  assign out_bus.out_data  = out_data_r;
  assign out_bus.out_index = idx_r;
  assign out_bus.out_last  = out_last_r;
  assign busy              = busy_r;
  assign load_ready        = load_ready_r;
  assign done              = done_r;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: a queue model of the expected word stream is
// compared every cycle, and literal stream/done expectations pin each scenario.
module tb_systolic_result_drain;
  localparam int BW = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [N*BW-1:0] data_in;
  logic            load_ready, busy, done;

  logic            load1;
  logic [BW-1:0]   data1;
  logic            load_ready1, busy1, done1;

  systolic_result_drain_if #(.BIT_WIDTH(BW), .INDEX_WIDTH(IW)) bus ();
  systolic_result_drain_if #(.BIT_WIDTH(BW), .INDEX_WIDTH(1))  bus1 ();

  systolic_result_drain #(.BIT_WIDTH(BW), .NUM_WORDS(N), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .load_ready(load_ready), .busy(busy), .done(done), .out_bus(bus)
  );

  systolic_result_drain #(.BIT_WIDTH(BW), .NUM_WORDS(1), .INDEX_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .data_in(data1),
    .load_ready(load_ready1), .busy(busy1), .done(done1), .out_bus(bus1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } item_t;

  item_t         exp_q [$];
  logic          exp_done;
  logic [BW-1:0] obs_q [$];
  logic [BW-1:0] exp_s [$];
  int            done_cnt;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input int k, input logic [N*BW-1:0] d);
    item_t it;
    it.data = d[k*BW +: BW];
    it.idx  = IW'(k);
    it.last = (k == N - 1);
    return it;
  endfunction

  // Model: a loaded snapshot becomes N queued words; a word leaves on each ready cycle
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_done <= 1'b0;
    end else begin
      exp_done <= (exp_q.size() == 1) && bus.out_ready;
      if (exp_q.size() != 0) begin
        if (bus.out_ready) void'(exp_q.pop_front());
      end else if (load) begin
        for (int k = 0; k < N; k++) exp_q.push_back(mk(k, data_in));
      end
    end
  end

  // Per-cycle comparison against the model, plus handshake/done logging
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("load_ready", 64'(load_ready), 64'(exp_q.size() == 0));
      check("done", 64'(done), 64'(exp_done));
      if (exp_q.size() != 0) begin
        check("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
        check("out_index", 64'(bus.out_index), 64'(exp_q[0].idx));
        check("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
      end
      if (!reset && bus.out_valid && bus.out_ready) obs_q.push_back(bus.out_data);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    obs_q.delete();
    exp_s.delete();
    done_cnt = 0;
  endtask

  task automatic check_stream(input string nm);
    check({nm, "_len"}, 64'(obs_q.size()), 64'(exp_s.size()));
    for (int i = 0; i < exp_s.size(); i++) begin
      if (i < obs_q.size()) check(nm, 64'(obs_q[i]), 64'(exp_s[i]));
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; data_in = '0; bus.out_ready = 1'b0;
    load1 = 1'b0; data1 = '0; bus1.out_ready = 1'b1;
    done_cnt = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_index", 64'(bus.out_index), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    step(1);

    // Basic drain
    clear_log();
    data_in = {32'h44, 32'h33, 32'h22, 32'h11};
    bus.out_ready = 1'b1;
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("basic_first_data", 64'(bus.out_data), 64'h11);
    check("basic_first_valid", 64'(bus.out_valid), 64'd1);
    step(8);
    exp_s = '{32'h11, 32'h22, 32'h33, 32'h44};
    check_stream("basic_stream");
    check("basic_done_cnt", 64'(done_cnt), 64'd1);
    check("basic_load_ready", 64'(load_ready), 64'd1);

    // Backpressure at index 1
    clear_log();
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_data", 64'(bus.out_data), 64'h22);
      check("stall_index", 64'(bus.out_index), 64'd1);
    end
    bus.out_ready = 1'b1;
    step(6);
    exp_s = '{32'h11, 32'h22, 32'h33, 32'h44};
    check_stream("stall_stream");
    check("stall_done_cnt", 64'(done_cnt), 64'd1);

    // Snapshot isolation and load ignored during drain
    clear_log();
    data_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    load = 1'b1;
    step(1);
    load = 1'b0;
    data_in = {N*BW{1'b1}};
    step(1);
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(8);
    exp_s = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    check_stream("iso_stream");
    check("iso_done_cnt", 64'(done_cnt), 64'd1);

    // Back-to-back loads: three drains with one idle cycle each
    clear_log();
    data_in = {32'h44, 32'h33, 32'h22, 32'h11};
    load = 1'b1;
    step(15);
    load = 1'b0;
    step(8);
    for (int r = 0; r < 3; r++) begin
      exp_s.push_back(32'h11); exp_s.push_back(32'h22);
      exp_s.push_back(32'h33); exp_s.push_back(32'h44);
    end
    check_stream("b2b_stream");
    check("b2b_done_cnt", 64'(done_cnt), 64'd3);

    // Reset after the word-1 handshake
    clear_log();
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    check("mid_rst_load_ready", 64'(load_ready), 64'd1);
    step(3);
    check("mid_rst_no_done", 64'(done_cnt), 64'd0);
    data_in = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("mid_rst_new_index", 64'(bus.out_index), 64'd0);
    step(8);
    exp_s = '{32'h11, 32'h22, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
    check_stream("mid_rst_stream");
    check("mid_rst_done_cnt", 64'(done_cnt), 64'd1);

    // Single-word build
    data1 = 32'hDEADBEEF;
    load1 = 1'b1;
    step(1);
    load1 = 1'b0;
    check("n1_valid", 64'(bus1.out_valid), 64'd1);
    check("n1_data", 64'(bus1.out_data), 64'hDEADBEEF);
    check("n1_index", 64'(bus1.out_index), 64'd0);
    check("n1_last", 64'(bus1.out_last), 64'd1);
    check("n1_busy", 64'(busy1), 64'd1);
    check("n1_load_ready", 64'(load_ready1), 64'd0);
    step(1);
    check("n1_valid_after", 64'(bus1.out_valid), 64'd0);
    check("n1_done", 64'(done1), 64'd1);
    check("n1_load_ready_after", 64'(load_ready1), 64'd1);
    step(1);
    check("n1_done_pulse", 64'(done1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Read-side counterpart to the write-enabled result registers in the standard systolic array.
- On a load pulse, captures a parallel snapshot of NUM_WORDS accumulator words from one array column or row.
- Streams the captured words out one per valid/ready handshake, with index and last markers.
- Sits between the array's result registers and the output buffer/host interface, so the array can start its next computation while results drain.

Parameters:
- BIT_WIDTH, 32, width of each result word.
- NUM_WORDS, 4, number of words captured per snapshot; legal range 1..16.
- INDEX_WIDTH, 2, width of out_index; must satisfy 2**INDEX_WIDTH >= NUM_WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture request; accepted only when load_ready=1.
- data_in  input  NUM_WORDS*BIT_WIDTH  parallel results; word k = data_in[k*BIT_WIDTH +: BIT_WIDTH].
- load_ready  output  1  high when block is IDLE and can accept load.
- out_valid  output  1  out_data/out_index/out_last hold a valid word.
- out_ready  input  1  downstream accepts the word when out_valid & out_ready.
- out_data  output  BIT_WIDTH  current word.
- out_index  output  INDEX_WIDTH  index k of current word.
- out_last  output  1  high while presenting word NUM_WORDS-1.
- busy  output  1  high in DRAIN state.
- done  output  1  one-cycle pulse after the final word handshake.

Behaviour:
- Reset (synchronous, active-high, clk):
  - state=IDLE, load_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
  - Internal snapshot storage cleared to 0.
- FSM states are IDLE and DRAIN.
- IDLE:
  - load_ready=1, out_valid=0.
  - load=1 at edge t captures all of data_in into the snapshot, sets index counter to 0, and goes to DRAIN.
  - At t+1: out_valid=1, out_data=word 0, out_index=0, busy=1, load_ready=0.
- DRAIN:
  - Presents snapshot[index].
  - On a handshake (out_valid & out_ready) with index<NUM_WORDS-1: index increments; the next word is presented the following cycle, so out_valid stays high with no bubble.
  - On a handshake with index==NUM_WORDS-1: go to IDLE; next cycle out_valid=0, busy=0, load_ready=1, done=1 for exactly one cycle.
- Stall: while out_valid=1 and out_ready=0, out_data, out_index and out_last must hold stable.
- Valid rule: out_valid never drops without a handshake, except on reset.
- Load outside IDLE: load ignored while load_ready=0, including the final-handshake cycle. data_in changes during DRAIN have no effect; the snapshot is frozen.
- Minimum load-to-load spacing: NUM_WORDS+1 cycles (one IDLE cycle between drains).
- out_last = (index==NUM_WORDS-1) & out_valid.
- NUM_WORDS=1: first word has out_last=1; a single handshake returns to IDLE.
- Index counter has no wrap-around; it is reset to 0 on every accepted load.
- out_data comes directly from the snapshot register selected by index. No arithmetic is applied and the word width is preserved.
- Reset mid-drain: takes effect at the next edge. The remaining words are discarded and done is not asserted.
- Simultaneous reset and load: reset wins.

Test Plan:
- Basic drain: NUM_WORDS=4, data_in={0x44,0x33,0x22,0x11}, pulse load, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after load; out_index 0..3; out_last only on 0x44; done 1 cycle later; load_ready back to 1.
- Backpressure: same data, out_ready low for 3 cycles while presenting index 1 -> out_data holds 0x22 and index holds 1 for all 3 cycles; the sequence then resumes with no word lost or duplicated.
- Snapshot isolation: load 0xA0..0xA3, then change data_in to 0xFF.. and pulse load during DRAIN -> the output stream is still 0xA0..0xA3; the second load is ignored (exactly 4 words, a single done).
- Back-to-back loads: hold load=1 continuously -> drains separated by exactly one IDLE cycle; each drain is 4 words; done pulses once per drain.
- Reset mid-drain: reset after word 1 handshake -> next cycle out_valid=0, out_data=0, load_ready=1, no done pulse; a new load then drains fresh data from index 0.
- NUM_WORDS=1 build: load 0xDEADBEEF -> one word with out_index=0 and out_last=1, then done.
